// File: rtl/mcdf_fmt_pkg.sv
// MCDF packet formatter shared types, length codes and length decode.
// Used by fmt_pkt_gen and fmt_pkt_buf.
package mcdf_fmt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REQ,
    ST_SEND,
    ST_GAP
  } fmt_state_e;

  localparam logic [2:0] LEN_SEL_4  = 3'b000;
  localparam logic [2:0] LEN_SEL_8  = 3'b001;
  localparam logic [2:0] LEN_SEL_16 = 3'b010;
  localparam logic [2:0] LEN_SEL_32 = 3'b011;

  function automatic int decode_len(
    input logic [2:0] sel,
    input int         max_len
  );
    int n;
    case (sel)
      LEN_SEL_4:  n = 4;
      LEN_SEL_8:  n = 8;
      LEN_SEL_16: n = 16;
      LEN_SEL_32: n = 32;
      default:    n = 32;
    endcase
    if (n > max_len) n = max_len;
    return n;
  endfunction

endpackage

// File: rtl/fmt_pkt_buf.sv
// Packet buffer: DEPTH x DW register array, one write port,
// one registered read port with a clear that zeroes the read register.
module fmt_pkt_buf
  import mcdf_fmt_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int DW    = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic          rd_clr_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || rd_clr_i) begin
      rd_q <= '0;
    end else if (rd_en_i) begin
      rd_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/fmt_pkt_gen.sv
// MCDF packet formatter: buffers a whole packet, then requests and streams it.
// Optional FMT_PARITY_EN adds a registered even-parity output fmt_parity_o.
module fmt_pkt_gen
  import mcdf_fmt_pkg::*;
#(
  parameter int CH_NUM  = 4,
  parameter int DW      = 32,
  parameter int MAX_LEN = 32,
  parameter int GAP_CYC = 1,
  localparam int IW     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  localparam int LW     = $clog2(MAX_LEN) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          a2f_val_i,
  input  logic [IW-1:0] a2f_id_i,
  input  logic [DW-1:0] a2f_data_i,
  input  logic [2:0]    a2f_pkglen_sel_i,
  output logic          f2a_ack_o,
  output logic          f2a_busy_o,
  input  logic          fmt_grant_i,
  output logic          fmt_req_o,
  output logic [IW-1:0] fmt_child_o,
  output logic [LW-1:0] fmt_length_o,
  output logic [DW-1:0] fmt_data_o,
  output logic          fmt_start_o,
`ifdef FMT_PARITY_EN
  output logic          fmt_end_o,
  output logic          fmt_parity_o
`else
  output logic          fmt_end_o
`endif
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
`ifdef FMT_PARITY_EN
  localparam int BW = DW + 1;
`else
  localparam int BW = DW;
`endif

  fmt_state_e state_q, state_d;
  logic [LW-1:0] wcnt_q, wcnt_d;
  logic [LW-1:0] rcnt_q, rcnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [IW-1:0] id_q, id_d;
  logic [LW-1:0] len_q, len_d;
  logic          req_q, start_q, start_d;
  logic          end_q, end_d;

  logic          ack;
  logic          wr_en, rd_en, rd_clr;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [BW-1:0] wr_data, rd_data;
  logic [LW-1:0] wnxt, rnxt, len_m1;

  assign wnxt   = wcnt_q + LW'(1);
  assign rnxt   = rcnt_q + LW'(1);
  assign len_m1 = len_q - LW'(1);

`ifdef FMT_PARITY_EN
  // parity travels with the word so it leaves on the same edge
  assign wr_data = {^a2f_data_i, a2f_data_i};
`else
  assign wr_data = a2f_data_i;
`endif

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    gap_d   = gap_q;
    id_d    = id_q;
    len_d   = len_q;
    ack     = 1'b0;
    wr_en   = 1'b0;
    wr_addr = wcnt_q[AW-1:0];
    rd_en   = 1'b0;
    rd_addr = rcnt_q[AW-1:0];
    start_d = 1'b0;
    end_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ack = a2f_val_i;
        if (a2f_val_i) begin
          id_d    = a2f_id_i;
          len_d   = LW'(decode_len(a2f_pkglen_sel_i, MAX_LEN));
          wr_en   = 1'b1;
          wr_addr = '0;
          wcnt_d  = LW'(1);
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ack = a2f_val_i;
        if (a2f_val_i) begin
          wr_en  = 1'b1;
          wcnt_d = wnxt;
          if (wnxt == len_q) state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (fmt_grant_i) begin
          state_d = ST_SEND;
          rcnt_d  = '0;
          wcnt_d  = '0;
          rd_en   = 1'b1;
          rd_addr = '0;
          start_d = 1'b1;
        end
      end
      ST_SEND: begin
        // rcnt_q indexes the word currently on fmt_data_o
        if (rcnt_q == len_m1) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end else begin
          rcnt_d  = rnxt;
          rd_en   = 1'b1;
          rd_addr = rnxt[AW-1:0];
          end_d   = (rnxt == len_m1);
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP_CYC - 1)) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_clr = (state_d != ST_SEND);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      gap_q   <= '0;
      id_q    <= '0;
      len_q   <= '0;
      req_q   <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      gap_q   <= gap_d;
      id_q    <= id_d;
      len_q   <= len_d;
      req_q   <= (state_d == ST_REQ);
      start_q <= start_d;
      end_q   <= end_d;
    end
  end

  fmt_pkt_buf #(
    .DEPTH (MAX_LEN),
    .DW    (BW)
  ) u_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_en_i   (rd_en),
    .rd_clr_i  (rd_clr),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign f2a_ack_o    = ack;
  assign f2a_busy_o   = (state_q == ST_REQ)
                     || (state_q == ST_SEND)
                     || (state_q == ST_GAP);
  assign fmt_req_o    = req_q;
  assign fmt_child_o  = id_q;
  assign fmt_length_o = len_q;
  assign fmt_data_o   = rd_data[DW-1:0];
  assign fmt_start_o  = start_q;
  assign fmt_end_o    = end_q;
`ifdef FMT_PARITY_EN
  assign fmt_parity_o = rd_data[DW];
`endif

endmodule

// File: doc/fmt_pkt_gen.md
# fmt_pkt_gen

Parametrised MCDF packet formatter, successor to the single-width pass-through formatter. Sits between the arbiter and the downstream MCDF output port. Accepts data words from the arbiter for the granted channel and buffers one complete packet internally. Only then does it request the downstream bus and stream the packet with self-generated start/end framing and an enforced inter-packet gap. It removes the need for an arbiter-side end signal and supports any channel count, data width and maximum packet depth.

## Interface
- CH_NUM, 4: number of slave channels; ID width IW = $clog2(CH_NUM), minimum 1.
- DW, 32: data word width.
- MAX_LEN, 32: packet buffer depth in words, power of two, ≥4; length width LW = $clog2(MAX_LEN)+1.
- GAP_CYC, 1: idle cycles after fmt_end_o before the next packet may load; ≥1.
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- a2f_val_i  in  1  arbiter word valid.
- a2f_id_i  in  IW  channel id of the current word.
- a2f_data_i  in  DW  data word.
- a2f_pkglen_sel_i  in  3  length code of the current packet.
- f2a_ack_o  out  1  word accepted this cycle (combinational).
- f2a_busy_o  out  1  formatter not accepting (REQ/SEND/GAP).
- fmt_grant_i  in  1  downstream grant.
- fmt_req_o  out  1  packet ready, requesting bus.
- fmt_child_o  out  IW  channel id of the packet being sent.
- fmt_length_o  out  LW  packet length in words.
- fmt_data_o  out  DW  data word.
- fmt_start_o  out  1  first word of packet.
- fmt_end_o  out  1  last word of packet.

## Operation
- States: IDLE, LOAD, REQ, SEND, GAP.
- Length decode: 000→4, 001→8, 010→16, 011→32, others→32, clamped to MAX_LEN. Result is registered as len_q.
- IDLE: f2a_ack_o = a2f_val_i. On acceptance, latch id and len_q, write the word to buf[0], set wcnt=1, go to LOAD.
- LOAD: f2a_ack_o = a2f_val_i. Each accepted word writes buf[wcnt] and increments wcnt. Id and length changes during LOAD are ignored. The accept that makes wcnt==len_q goes to REQ.
- REQ: fmt_req_o=1, f2a_ack_o=0. fmt_grant_i sampled high with fmt_req_o high moves to SEND with rcnt=0.
- SEND: one word per cycle from buf[rcnt], rcnt increments. fmt_start_o=1 when rcnt==0; fmt_end_o=1 when rcnt==len_q-1. The end cycle goes to GAP.
- GAP: counts GAP_CYC cycles, then IDLE.
- fmt_grant_i outside REQ is ignored. a2f_val_i outside IDLE/LOAD is ignored and f2a_ack_o stays 0.
- fmt_child_o and fmt_length_o hold the latched values from LOAD entry until the next IDLE acceptance.

## Timing
- Reset values: state IDLE; fmt_req_o, fmt_start_o, fmt_end_o, f2a_busy_o = 0; fmt_data_o, fmt_child_o = 0; fmt_length_o = 0; wcnt, rcnt, gap counter = 0. Buffer contents are don't-care.
- All fmt_* outputs are registered; f2a_ack_o is combinational from state and a2f_val_i.
- fmt_req_o rises the cycle after the final accepted word.
- First data cycle (fmt_start_o) is the cycle after grant is sampled.
- Packet of N words occupies exactly N SEND cycles with no bubbles. N=4 gives start and end 3 cycles apart.
- Minimum back-to-back spacing is fmt_end_o to next f2a_ack_o = GAP_CYC+1 cycles.
- Grant asserted in the same cycle fmt_req_o first rises counts. Grant held high through SEND has no effect.
- A reset at any point, including mid-LOAD or mid-SEND, aborts the packet. Outputs return to their reset values next cycle and no partial end is emitted.

## Configuration
- FMT_PARITY_EN defined: adds output fmt_parity_o (1 bit, registered). It carries the even parity (XOR reduce) of fmt_data_o, valid in SEND cycles and 0 otherwise, including at reset.
- FMT_PARITY_EN undefined: the port and its logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package mcdf_fmt_pkg holds: the state enum; the length-code constants (LEN_SEL_4…LEN_SEL_32); and the function decode_len(sel, max_len).
- One sub-module, fmt_pkt_buf: a single-port-write, single-port-read register array MAX_LEN×DW with a registered read. The FSM and counters live in the top.

## Test plan
- Reset, then sel=000, id=2, words 0xA0..0xA3 presented back-to-back → ack on 4 cycles, req next cycle. With grant high, the following 4 cycles output A0..A3; start on A0, end on A3, child=2, length=4.
- sel=011, val toggling every other cycle → 32 accepts, packet streamed contiguous. Id/sel changes mid-LOAD do not alter child or length.
- Grant held low for 10 cycles in REQ → req stays high, ack stays 0 despite val=1. Grant then high → SEND starts the next cycle.
- Two packets back-to-back with GAP_CYC=3 → exactly 4 cycles from end to the next ack.
- Reset pulsed on the 3rd SEND word → no end, req=0, and a new 8-word packet loads cleanly afterwards.
- FMT_PARITY_EN with data 0x00000007 → fmt_parity_o=1; with 0x00000003 → 0.
